load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a decode/execute result, issues one data-memory access
// at a time, and writes ALU or extended load results to the register file.
// Optional: define MISALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module load_store_unit #(
  parameter logic [6:0] OP_LOAD  = 7'b0000011,
  parameter logic [6:0] OP_STORE = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        wb_reg,
  input  logic [4:0]  rd_num,
  input  logic [31:0] rd_data,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;
  logic [2:0]  ld_func3;
  logic [1:0]  ld_off;
  logic [4:0]  ld_rd;
  logic        ld_wb;

  logic        take;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  off;
  logic        rf_en;
  logic        mis;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // Stores: byte/halfword lanes are selected by the low address bits and the
  // data is replicated so the memory can pick any lane; anything else is a word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic ld, input logic [2:0] f3, input logic [1:0] a);
    logic half;
    logic word;
    half = ld ? (f3 == F3_H || f3 == F3_HU) : (f3 == F3_H);
    word = ld ? !(f3 == F3_B || f3 == F3_BU || f3 == F3_H || f3 == F3_HU)
              : !(f3 == F3_B || f3 == F3_H);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign take      = in_valid && in_ready;
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_mem    = is_load || is_store;
  assign off       = rd_data[1:0];
  assign rf_en     = wb_reg && (rd_num != 5'd0);
  assign req_be    = is_store ? store_be(func3, off) : 4'b1111;
  assign req_wdata = is_store ? store_lanes(func3, store_data) : 32'd0;

`ifdef MISALIGN_CHECK_EN
  assign mis = misaligned(is_load, func3, off);
`else
  assign mis = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // NOTE: every register here is assigned with <= so all state updates see the
  // values from before the edge; mixing in = would make ordering matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole datapath is cleared, not just the state, because every
      // output is observable as zero during reset.
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      ld_func3   <= 3'd0;
      ld_off     <= 2'd0;
      ld_rd      <= 5'd0;
      ld_wb      <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      rf_we <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (take) begin
            if (!is_mem) begin
              rf_we    <= rf_en;
              rf_waddr <= rd_num;
              rf_wdata <= rd_data;
            end else if (mis) begin
`ifdef MISALIGN_CHECK_EN
              misalign_err <= 1'b1;
`endif
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {rd_data[31:2], 2'b00};
              dmem_be    <= req_be;
              dmem_wdata <= req_wdata;
              ld_func3   <= func3;
              ld_off     <= off;
              ld_rd      <= rd_num;
              ld_wb      <= rf_en;
            end
          end
        end
        REQ: begin
          // Request fields stay frozen until the grant; a store is done once granted.
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state    <= IDLE;
            rf_we    <= ld_wb;
            rf_waddr <= ld_rd;
            rf_wdata <= load_extend(ld_func3, ld_off, dmem_rdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner
// sequences and randomized transactions against a transaction-level model.
module tb_load_store_unit;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic        wb_reg = 1'b0;
  logic [4:0]  rd_num = '0;
  logic [31:0] rd_data = '0;
  logic [31:0] store_data = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.OP_LOAD(LD), .OP_STORE(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .wb_reg(wb_reg), .rd_num(rd_num),
    .rd_data(rd_data), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] sd;
    int          gnt_dly;
    logic [31:0] rdat;
    int          rv_dly;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_rfwe;
    logic [31:0] x_rfdata;
    logic        x_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 1'b0;
  endtask

  // Busy-cycle noise: offers that must be ignored, random read data on the bus.
  task automatic junk();
    in_valid   = 1'($urandom);
    opcode     = ALU;
    wb_reg     = 1'b1;
    rd_num     = 5'($urandom_range(1, 31));
    rd_data    = $urandom;
    store_data = $urandom;
    dmem_rdata = $urandom;
  endtask

  // Reference model: lane arithmetic straight from the access-size rules.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic vec_t make_vec(input logic [6:0] op, input logic [2:0] f3, input logic wb,
                                    input logic [4:0] rd, input logic [31:0] a,
                                    input logic [31:0] sd, input int gd,
                                    input logic [31:0] rdat, input int rvd);
    vec_t v;
    logic [1:0] off;
    bit st, half, word;
    off = a[1:0];
    st  = (op == ST);
    v = '{op, f3, wb, rd, a, sd, gd, rdat, rvd, a & ~32'h3, 4'hF, sd, 1'b0, 32'd0, 1'b0};
    v.x_rfwe = wb && (rd != 0);
    if (op == ALU) begin
      v.x_rfdata = a;
    end else if (st) begin
      v.x_rfwe = 1'b0;
      if (f3 == 3'b000) begin
        v.x_be = 4'(1 << off);
        v.x_wdata = (sd & 32'hFF) * 32'h01010101;
      end else if (f3 == 3'b001) begin
        v.x_be = 4'(3 << (2 * (off / 2)));
        v.x_wdata = (sd & 32'hFFFF) * 32'h00010001;
      end
    end else begin
      v.x_rfdata = ld_model(f3, off, rdat);
    end
    if (op != ALU) begin
      half = st ? (f3 == 1) : (f3 == 1 || f3 == 5);
      word = st ? (f3 > 1) : !(f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5);
      v.x_mis = MIS_EN && ((half && off[0]) || (word && off != 0));
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    bit st, ld;
    st = (v.op == ST);
    ld = (v.op == LD);
    check("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = v.op; func3 = v.f3; wb_reg = v.wb; rd_num = v.rd;
    rd_data = v.a; store_data = v.sd;
    tick();
    if (!(st || ld)) begin
      quiet();
      check("alu_rf_we", 32'(rf_we), 32'(v.x_rfwe));
      if (v.x_rfwe) begin
        check("alu_waddr", 32'(rf_waddr), 32'(v.rd));
        check("alu_wdata", rf_wdata, v.x_rfdata);
      end
      check("alu_no_req", 32'(dmem_req), 32'd0);
      tick();
      check("alu_pulse_end", 32'(rf_we), 32'd0);
    end else if (v.x_mis) begin
      quiet();
      check("mis_err", 32'(misalign_err), 32'd1);
      check("mis_no_req", 32'(dmem_req), 32'd0);
      check("mis_ready", 32'(in_ready), 32'd1);
      tick();
      check("mis_err_end", 32'(misalign_err), 32'd0);
      check("mis_no_req2", 32'(dmem_req), 32'd0);
      check("mis_no_rf", 32'(rf_we), 32'd0);
    end else begin
      check("no_mis_err", 32'(misalign_err), 32'd0);
      for (int i = 0; i <= v.gnt_dly; i++) begin
        check("req", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(st));
        check("addr", dmem_addr, v.x_addr);
        check("be", 32'(dmem_be), 32'(v.x_be));
        if (st) check("wdata", dmem_wdata, v.x_wdata);
        check("busy_ready", 32'(in_ready), 32'd0);
        check("busy_rf_we", 32'(rf_we), 32'd0);
        junk();
        dmem_rvalid = 1'($urandom);
        dmem_gnt = (i == v.gnt_dly);
        tick();
      end
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      check("req_dropped", 32'(dmem_req), 32'd0);
      if (st) begin
        quiet();
        check("st_no_rf", 32'(rf_we), 32'd0);
        check("st_ready", 32'(in_ready), 32'd1);
      end else begin
        for (int j = 0; j < v.rv_dly; j++) begin
          junk();
          tick();
          check("wait_rf_we", 32'(rf_we), 32'd0);
          check("wait_ready", 32'(in_ready), 32'd0);
        end
        junk();
        dmem_rvalid = 1'b1;
        dmem_rdata = v.rdat;
        tick();
        dmem_rvalid = 1'b0;
        quiet();
        check("ld_rf_we", 32'(rf_we), 32'(v.x_rfwe));
        if (v.x_rfwe) begin
          check("ld_waddr", 32'(rf_waddr), 32'(v.rd));
          check("ld_wdata", rf_wdata, v.x_rfdata);
        end
        check("ld_ready", 32'(in_ready), 32'd1);
        tick();
        check("ld_pulse_end", 32'(rf_we), 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'(|{dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                      rf_we, rf_waddr, rf_wdata, misalign_err}), 32'd0);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{ALU, 3'b000, 1, 5,  32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0};
    tbl[1]  = '{ST, 3'b000, 0, 0, 32'h103, 32'hAB, 2, 0, 0,
                32'h100, 4'b1000, 32'hABABABAB, 0, 0, 0};
    tbl[2]  = '{LD, 3'b000, 1, 3, 32'h102, 0, 0, 32'h00800000, 1,
                32'h100, 4'hF, 0, 1, 32'hFFFFFF80, 0};
    tbl[3]  = '{LD, 3'b100, 1, 4, 32'h102, 0, 1, 32'h00800000, 0,
                32'h100, 4'hF, 0, 1, 32'h00000080, 0};
    tbl[4]  = '{LD, 3'b010, 1, 0, 32'h200, 0, 0, 32'h55, 0, 32'h200, 4'hF, 0, 0, 0, 0};
    tbl[5]  = '{ST, 3'b010, 0, 0, 32'h102, 32'h11223344, 0, 0, 0,
                32'h100, 4'hF, 32'h11223344, 0, 0, MIS_EN};
    tbl[6]  = '{ALU, 3'b000, 0, 9, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{ALU, 3'b000, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{ST, 3'b001, 0, 0, 32'h106, 32'h1234CDEF, 1, 0, 0,
                32'h104, 4'b1100, 32'hCDEFCDEF, 0, 0, 0};
    tbl[9]  = '{LD, 3'b001, 1, 10, 32'h102, 0, 0, 32'h80010000, 0,
                32'h100, 4'hF, 0, 1, 32'hFFFF8001, 0};
    tbl[10] = '{LD, 3'b101, 1, 11, 32'h102, 0, 0, 32'h80010000, 0,
                32'h100, 4'hF, 0, 1, 32'h00008001, 0};
    tbl[11] = '{LD, 3'b111, 1, 12, 32'h40, 0, 0, 32'hDEADBEEF, 2,
                32'h40, 4'hF, 0, 1, 32'hDEADBEEF, 0};
    tbl[12] = '{ST, 3'b011, 0, 0, 32'h44, 32'hCAFEF00D, 0, 0, 0,
                32'h44, 4'hF, 32'hCAFEF00D, 0, 0, 0};
    tbl[13] = '{LD, 3'b001, 1, 13, 32'h103, 0, 0, 32'h7FFF0000, 0,
                32'h100, 4'hF, 0, 1, 32'h00007FFF, MIS_EN};
    tbl[14] = '{LD, 3'b000, 0, 6, 32'h101, 0, 0, 32'h0000FF00, 0,
                32'h100, 4'hF, 0, 0, 0, 0};
    tbl[15] = '{ST, 3'b000, 0, 0, 32'h100, 32'h1FF, 0, 0, 0,
                32'h100, 4'b0001, 32'hFFFFFFFF, 0, 0, 0};
    tbl[16] = '{LD, 3'b010, 1, 14, 32'h3, 0, 1, 32'h12345678, 1,
                32'h0, 4'hF, 0, 1, 32'h12345678, MIS_EN};

    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) run_op(tbl[i]);

    // Reset while a store waits for its grant; the late grant must be ignored.
    run_op(make_vec(ALU, 0, 1, 1, 32'h1, 0, 0, 0, 0));
    in_valid = 1'b1; opcode = ST; func3 = 3'b010; rd_data = 32'h80; store_data = 32'h5A5A;
    tick();
    quiet();
    check("rq_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_in_req");
    rst = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rq_late_gnt_req", 32'(dmem_req), 32'd0);
    check("rq_late_gnt_ready", 32'(in_ready), 32'd1);
    check("rq_late_gnt_rf", 32'(rf_we), 32'd0);

    // Reset while a load waits for data; rvalid during and after reset is dropped.
    in_valid = 1'b1; opcode = LD; func3 = 3'b010; wb_reg = 1'b1; rd_num = 5'd7;
    rd_data = 32'h10;
    tick();
    quiet();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rw_in_wait_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_in_wait");
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hFEEDFACE;
    tick();
    check_reset_outputs("rst_rvalid");
    rst = 1'b0;
    tick();
    check("rw_late_rvalid_rf", 32'(rf_we), 32'd0);
    check("rw_late_ready", 32'(in_ready), 32'd1);
    dmem_rvalid = 1'b0;
    tick();
    check("rw_late_rf2", 32'(rf_we), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      int k;
      k = $urandom_range(0, 2);
      op = (k == 0) ? ALU : (k == 1) ? LD : ST;
      f3 = 3'($urandom);
      if (op == ST && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b010;
      run_op(make_vec(op, f3, 1'($urandom), 5'($urandom), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom, $urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
